// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, FSM states, access sizes.
package mem_stage_lsu_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned DATA_W = 32;

    localparam logic [OP_W-1:0] EXE_LB_OP  = 8'hE0;
    localparam logic [OP_W-1:0] EXE_LH_OP  = 8'hE1;
    localparam logic [OP_W-1:0] EXE_LW_OP  = 8'hE3;
    localparam logic [OP_W-1:0] EXE_LBU_OP = 8'hE4;
    localparam logic [OP_W-1:0] EXE_LHU_OP = 8'hE5;
    localparam logic [OP_W-1:0] EXE_SB_OP  = 8'hE8;
    localparam logic [OP_W-1:0] EXE_SH_OP  = 8'hE9;
    localparam logic [OP_W-1:0] EXE_SW_OP  = 8'hEB;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } lsu_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic [1:0] op_size(input logic [OP_W-1:0] op);
        logic [1:0] sz;
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: sz = SIZE_H;
            EXE_LW_OP, EXE_SW_OP:             sz = SIZE_W;
            default:                          sz = SIZE_B;
        endcase
        return sz;
    endfunction

    function automatic logic misaligned(input logic [OP_W-1:0] op, input logic [1:0] a);
        logic m;
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: m = a[0];
            EXE_LW_OP, EXE_SW_OP:             m = |a;
            default:                          m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_ext.sv
// Load result extraction: selects the byte/half lane of a raw bus word and sign/zero-extends it.
module mem_stage_lsu_load_ext
    import mem_stage_lsu_pkg::*;
(
    input  logic [OP_W-1:0]   i_op,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_raw,
    output logic [DATA_W-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_raw[7:0];
            2'd1:    w_byte = i_raw[15:8];
            2'd2:    w_byte = i_raw[23:16];
            default: w_byte = i_raw[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];
    end

    // Non-load ops (stores included) yield zero.
    always_comb begin
        case (i_op)
            EXE_LB_OP:  o_data = {{24{w_byte[7]}}, w_byte};
            EXE_LBU_OP: o_data = {24'h0, w_byte};
            EXE_LH_OP:  o_data = {{16{w_half[15]}}, w_half};
            EXE_LHU_OP: o_data = {16'h0, w_half};
            EXE_LW_OP:  o_data = i_raw;
            default:    o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: alignment check, single-outstanding req/addr_ok/data_ok bus master,
// store lane placement and extended load result with pipeline stall.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter bit          STORE_REPLICATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              flush_i,
    input  logic              adv_i,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              stall_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic [31:0]       badvaddr_o
);

    lsu_state_e        r_state;
    lsu_state_e        w_next;
    logic [OP_W-1:0]   r_op;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              w_is_mem;
    logic              w_misalign;
    logic              w_start;
    logic              w_req;
    logic              w_stall;
    logic              w_cap_rdata;
    logic [31:0]       w_lane_wdata;

    // Reset gates the combinational paths so every output reads zero while rst is low.
    always_comb begin
        w_is_mem   = is_load(op_i) | is_store(op_i);
        w_misalign = w_is_mem & misaligned(op_i, addr_i[1:0]);
        w_start    = rst & mem_valid_i & w_is_mem & ~w_misalign & ~flush_i & (r_state == ST_IDLE);
        adel_o     = rst & mem_valid_i & w_misalign & is_load(op_i);
        ades_o     = rst & mem_valid_i & w_misalign & is_store(op_i);
        badvaddr_o = (adel_o | ades_o) ? addr_i : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // A flush with addr_ok already seen must drain the pending data_ok before going idle.
    always_comb begin
        w_next      = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_cap_rdata = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next  = ST_REQ;
                    w_stall = 1'b1;
                end
            end
            ST_REQ: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (data_addr_ok) begin
                    if (flush_i)           w_next = data_data_ok ? ST_IDLE : ST_DRAIN;
                    else if (data_data_ok) begin
                        w_next      = ST_DONE;
                        w_cap_rdata = 1'b1;
                    end
                    else                   w_next = ST_WAIT;
                end else if (flush_i) begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_stall = 1'b1;
                if (flush_i)           w_next = data_data_ok ? ST_IDLE : ST_DRAIN;
                else if (data_data_ok) begin
                    w_next      = ST_DONE;
                    w_cap_rdata = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_stall = 1'b1;
                if (data_data_ok) w_next = ST_IDLE;
            end
            ST_DONE: begin
                if (adv_i | flush_i) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                r_op    <= op_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
            end
            if (w_cap_rdata) r_rdata <= data_rdata;
        end
    end

    always_comb begin
        case (r_op)
            EXE_SB_OP: w_lane_wdata = STORE_REPLICATE ? {4{r_wdata[7:0]}}
                                    : (DATA_W'(r_wdata[7:0]) << {r_addr[1:0], 3'b000});
            EXE_SH_OP: w_lane_wdata = STORE_REPLICATE ? {2{r_wdata[15:0]}}
                                    : (r_addr[1] ? {r_wdata[15:0], 16'h0} : {16'h0, r_wdata[15:0]});
            default:   w_lane_wdata = r_wdata;
        endcase
    end

    mem_stage_lsu_load_ext u_load_ext (
        .i_op      (r_op),
        .i_addr_lo (r_addr[1:0]),
        .i_raw     (r_rdata),
        .o_data    (rdata_o)
    );

    assign data_req   = w_req;
    assign stall_o    = w_stall;
    assign done_o     = (r_state == ST_DONE);
    assign data_wr    = is_store(r_op);
    assign data_size  = op_size(r_op);
    assign data_addr  = r_addr[ADDR_W-1:0];
    assign data_wdata = w_lane_wdata;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads, stores, misalignment, bus waits, flush and reset.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [7:0]  op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        adv_i;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        stall_o;
    logic        adel_o;
    logic        ades_o;
    logic [31:0] badvaddr_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(32), .STORE_REPLICATE(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid_i  (mem_valid_i),
        .op_i         (op_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .flush_i      (flush_i),
        .adv_i        (adv_i),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .rdata_o      (rdata_o),
        .done_o       (done_o),
        .stall_o      (stall_o),
        .adel_o       (adel_o),
        .ades_o       (ades_o),
        .badvaddr_o   (badvaddr_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd);
        mem_valid_i = 1'b1;
        op_i        = op;
        addr_i      = addr;
        wdata_i     = wd;
        #1;
    endtask

    task automatic load0(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] raw,
                         input logic [31:0] exp, input string tag);
        issue(op, addr, 32'h0);
        tick();
        mem_valid_i  = 1'b0;
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = raw;
        #1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        #1;
        chk({tag, "_rdata"}, rdata_o, exp);
        chk({tag, "_done"}, 32'(done_o), 32'h1);
        adv_i = 1'b1;
        tick();
        adv_i = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0; mem_valid_i = 1'b0; op_i = 8'h0; addr_i = 32'h0; wdata_i = 32'h0;
        flush_i = 1'b0; adv_i = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        #12;
        chk("rst_req",   32'(data_req), 32'h0);
        chk("rst_done",  32'(done_o),   32'h0);
        chk("rst_rdata", rdata_o,       32'h0);
        chk("rst_addr",  data_addr,     32'h0);
        issue(EXE_LW_OP, 32'h1000_0002, 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_adel",  32'(adel_o),  32'h0);
        mem_valid_i = 1'b0;
        rst = 1'b1;
        tick();

        // LW zero-wait: done_o two cycles after start
        issue(EXE_LW_OP, 32'h1000_0004, 32'h0);
        chk("lw_start_stall", 32'(stall_o), 32'h1);
        chk("lw_start_req",   32'(data_req), 32'h0);
        tick();
        mem_valid_i = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        #1;
        chk("lw_req",  32'(data_req),  32'h1);
        chk("lw_size", 32'(data_size), 32'h2);
        chk("lw_wr",   32'(data_wr),   32'h0);
        chk("lw_addr", data_addr,      32'h1000_0004);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        chk("lw_done",  32'(done_o),  32'h1);
        chk("lw_rdata", rdata_o,      32'hDEAD_BEEF);
        chk("lw_stall", 32'(stall_o), 32'h0);
        adv_i = 1'b1;
        tick();
        adv_i = 1'b0;
        #1;
        chk("lw_idle_done", 32'(done_o), 32'h0);

        load0(EXE_LB_OP,  32'h1000_0003, 32'h80FF_0000, 32'hFFFF_FF80, "lb");
        load0(EXE_LBU_OP, 32'h1000_0003, 32'h80FF_0000, 32'h0000_0080, "lbu");
        load0(EXE_LH_OP,  32'h1000_0002, 32'h80FF_0000, 32'hFFFF_80FF, "lh");
        load0(EXE_LHU_OP, 32'h1000_0000, 32'h1234_9876, 32'h0000_9876, "lhu");

        // SB with one wait cycle on data_ok
        issue(EXE_SB_OP, 32'h1000_0001, 32'h1234_56AB);
        tick();
        mem_valid_i = 1'b0; data_addr_ok = 1'b1;
        #1;
        chk("sb_wdata", data_wdata,     32'hABAB_ABAB);
        chk("sb_size",  32'(data_size), 32'h0);
        chk("sb_wr",    32'(data_wr),   32'h1);
        tick();
        data_addr_ok = 1'b0;
        #1;
        chk("sb_wait_done",  32'(done_o),  32'h0);
        chk("sb_wait_stall", 32'(stall_o), 32'h1);
        chk("sb_wait_req",   32'(data_req), 32'h0);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("sb_done",  32'(done_o), 32'h1);
        chk("sb_rdata", rdata_o,     32'h0);
        adv_i = 1'b1;
        tick();
        adv_i = 1'b0;

        // SH replicated half
        issue(EXE_SH_OP, 32'h1000_0002, 32'h0000_BEEF);
        tick();
        mem_valid_i = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b1;
        #1;
        chk("sh_wdata", data_wdata,     32'hBEEF_BEEF);
        chk("sh_size",  32'(data_size), 32'h1);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        adv_i = 1'b1;
        tick();
        adv_i = 1'b0;

        // misaligned accesses never reach the bus
        issue(EXE_LW_OP, 32'h1000_0002, 32'h0);
        chk("mis_adel",  32'(adel_o),  32'h1);
        chk("mis_ades0", 32'(ades_o),  32'h0);
        chk("mis_bad",   badvaddr_o,   32'h1000_0002);
        chk("mis_stall", 32'(stall_o), 32'h0);
        tick();
        chk("mis_req",   32'(data_req), 32'h0);
        issue(EXE_SH_OP, 32'h1000_0001, 32'h0);
        chk("mis_ades",  32'(ades_o),  32'h1);
        chk("mis_adel0", 32'(adel_o),  32'h0);
        chk("mis_bad_sh", badvaddr_o,  32'h1000_0001);
        mem_valid_i = 1'b0;
        tick();

        // SW with addr_ok after 3 cycles, data_ok 2 cycles later
        issue(EXE_SW_OP, 32'h2000_0008, 32'hCAFE_F00D);
        tick();
        mem_valid_i = 1'b0; addr_i = 32'hFFFF_FFFC; wdata_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            data_addr_ok = (i == 3);
            #1;
            chk("w5_req",   32'(data_req), 32'h1);
            chk("w5_addr",  data_addr,     32'h2000_0008);
            chk("w5_wdata", data_wdata,    32'hCAFE_F00D);
            chk("w5_stall", 32'(stall_o),  32'h1);
            tick();
        end
        data_addr_ok = 1'b0;
        #1;
        chk("w5_wait_req",   32'(data_req), 32'h0);
        chk("w5_wait_stall", 32'(stall_o),  32'h1);
        tick();
        data_data_ok = 1'b1;
        #1;
        chk("w5_wait2_done", 32'(done_o), 32'h0);
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("w5_done",  32'(done_o),  32'h1);
        chk("w5_stall_done", 32'(stall_o), 32'h0);
        adv_i = 1'b1;
        tick();
        adv_i = 1'b0;

        // flush in WAIT drains the pending data_ok without done_o
        issue(EXE_LW_OP, 32'h1000_0010, 32'h0);
        tick();
        mem_valid_i = 1'b0; data_addr_ok = 1'b1;
        #1;
        tick();
        data_addr_ok = 1'b0; flush_i = 1'b1;
        #1;
        chk("fl_wait_stall", 32'(stall_o), 32'h1);
        tick();
        flush_i = 1'b0;
        #1;
        chk("fl_drain_stall", 32'(stall_o),  32'h1);
        chk("fl_drain_req",   32'(data_req), 32'h0);
        chk("fl_drain_done",  32'(done_o),   32'h0);
        tick();
        data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
        #1;
        chk("fl_drain2_stall", 32'(stall_o), 32'h1);
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("fl_idle_done",  32'(done_o),  32'h0);
        chk("fl_idle_stall", 32'(stall_o), 32'h0);

        // flush in REQ before addr_ok drops the request
        issue(EXE_LW_OP, 32'h1000_0014, 32'h0);
        tick();
        mem_valid_i = 1'b0; flush_i = 1'b1;
        #1;
        chk("flr_req", 32'(data_req), 32'h1);
        tick();
        flush_i = 1'b0;
        #1;
        chk("flr_idle_req",   32'(data_req), 32'h0);
        chk("flr_idle_stall", 32'(stall_o),  32'h0);
        chk("flr_idle_done",  32'(done_o),   32'h0);

        // asynchronous reset during REQ
        issue(EXE_LW_OP, 32'h1000_0018, 32'h0);
        tick();
        mem_valid_i = 1'b0;
        #1;
        chk("ar_req_pre", 32'(data_req), 32'h1);
        rst = 1'b0;
        #1;
        chk("ar_req",   32'(data_req), 32'h0);
        chk("ar_stall", 32'(stall_o),  32'h0);
        chk("ar_addr",  data_addr,     32'h0);
        rst = 1'b1;
        tick();
        data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("ar_late_ok_done",  32'(done_o),  32'h0);
        chk("ar_late_ok_stall", 32'(stall_o), 32'h0);
        chk("ar_late_ok_rdata", rdata_o,      32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
